// File: rtl/burst_adaptor_pkg.sv
// Shared types and parameter helpers for the burst line adaptor.
// Consumers derive beat count and line-offset width from these functions.
package burst_adaptor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  function automatic int unsigned calc_beats(input int unsigned line_w,
                                             input int unsigned burst_w);
    return line_w / burst_w;
  endfunction

  function automatic int unsigned calc_offset_bits(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index within a line burst: synchronous clear, count enable, last-beat flag.
module burst_beat_counter #(
  parameter int unsigned BEATS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  output logic [$clog2(BEATS)-1:0] beat,
  output logic                     last
);

  localparam int unsigned CntW = $clog2(BEATS);

  logic [CntW-1:0] beat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
    end else if (clear) begin
      beat_q <= '0;
    end else if (enable) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  assign beat = beat_q;
  assign last = (beat_q == CntW'(BEATS - 1));

endmodule

// File: rtl/burst_line_adaptor.sv
// Splits one LLC line read/write into BEATS memory beats, tolerating stalls between beats.
// Define BURST_LINE_ADAPTOR_POSTED_WRITE_EN to release the LLC at the start of a write burst.
module burst_line_adaptor
  import burst_adaptor_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int unsigned Beats   = calc_beats(LINE_WIDTH, BURST_WIDTH);
  localparam int unsigned OffBits = calc_offset_bits(LINE_WIDTH);
  localparam int unsigned CntW    = $clog2(Beats);
  localparam int unsigned LsbW    = $clog2(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AddrMask =
      {{(ADDR_WIDTH - OffBits){1'b1}}, {OffBits{1'b0}}};

`ifdef BURST_LINE_ADAPTOR_POSTED_WRITE_EN
  localparam bit PostedWrite = 1'b1;
`else
  localparam bit PostedWrite = 1'b0;
`endif

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wbuf_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic                    read_q;
  logic                    write_q;
  logic                    resp_q;

  logic                    accept;
  logic                    beat_en;
  logic [CntW-1:0]         beat;
  logic                    last;
  logic [LsbW-1:0]         beat_lsb;

  assign accept   = (state_q == StIdle) && (read_i || write_i);
  assign beat_en  = resp_i && ((state_q == StRead) || (state_q == StWrite));
  assign beat_lsb = LsbW'(beat * BURST_WIDTH);

  burst_beat_counter #(
    .BEATS (Beats)
  ) u_beat_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (beat_en),
    .beat   (beat),
    .last   (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Read wins when both strobes are high; the write stays pending.
          if (read_i) begin
            state_q <= StRead;
            addr_q  <= address_i & AddrMask;
            read_q  <= 1'b1;
          end else if (write_i) begin
            state_q <= StWrite;
            addr_q  <= address_i & AddrMask;
            wbuf_q  <= line_i;
            write_q <= 1'b1;
            resp_q  <= PostedWrite;
          end
        end
        StRead: begin
          if (resp_i) begin
            line_q[beat_lsb +: BURST_WIDTH] <= burst_i;
            if (last) begin
              state_q <= StDone;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (resp_i && last) begin
            write_q <= 1'b0;
            if (PostedWrite) begin
              state_q <= StIdle;
            end else begin
              state_q <= StDone;
              resp_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
  assign burst_o   = (state_q == StWrite) ? wbuf_q[beat_lsb +: BURST_WIDTH] : '0;

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Directed bench for burst_line_adaptor at default widths; posted-write checks follow the
// BURST_LINE_ADAPTOR_POSTED_WRITE_EN macro.
module tb_burst_line_adaptor;

  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;
  localparam int unsigned AW = 32;

`ifdef BURST_LINE_ADAPTOR_POSTED_WRITE_EN
  localparam bit Posted = 1'b1;
`else
  localparam bit Posted = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [LW-1:0] line_i;
  logic [LW-1:0] line_o;
  logic [AW-1:0] address_i;
  logic [AW-1:0] address_o;
  logic          read_i;
  logic          write_i;
  logic          resp_o;
  logic [BW-1:0] burst_i;
  logic [BW-1:0] burst_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [63:0]  rd_words [4];
  logic [63:0]  wr_words [4];
  logic [255:0] rd_line;
  logic [255:0] wr_line;
  logic [255:0] both_line;
  logic [255:0] rev_line;
  logic [255:0] stall_line;
  bit           stall_pat [7];

  burst_line_adaptor dut (
    .clk       (clk),
    .reset     (reset),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    chk(tag, 256'(obs), 256'(exp));
  endtask

  task automatic chk_a(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk(tag, 256'(obs), 256'(exp));
  endtask

  task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk(tag, 256'(obs), 256'(exp));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rd_words   = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    wr_words   = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA};
    rd_line    = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    rev_line   = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    wr_line    = {64'h5555_AAAA_5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0,
                  64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    both_line  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA};
    stall_line = {64'hC0DE_0000_0000_0006, 64'hC0DE_0000_0000_0004,
                  64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0000};
    stall_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;

    // Reset state
    tick();
    chk_b("rst_read_o", read_o, 1'b0);
    chk_b("rst_write_o", write_o, 1'b0);
    chk_b("rst_resp_o", resp_o, 1'b0);
    chk("rst_line_o", line_o, 256'h0);
    chk_a("rst_address_o", address_o, 32'h0);
    chk_w("rst_burst_o", burst_o, 64'h0);
    reset = 1'b0;
    tick();

    // Plain read, no stalls: cycle 0 request, beats in cycles 1..4, resp_o in cycle 5
    read_i = 1'b1; address_i = 32'h1234_5677;
    tick();
    chk_a("rd_addr", address_o, 32'h1234_5660);
    for (int i = 0; i < 4; i++) begin
      chk_b("rd_read_o", read_o, 1'b1);
      chk_b("rd_no_resp", resp_o, 1'b0);
      resp_i = 1'b1; burst_i = rd_words[i];
      tick();
    end
    resp_i = 1'b0;
    chk_b("rd_resp", resp_o, 1'b1);
    chk_b("rd_read_o_low", read_o, 1'b0);
    chk("rd_line", line_o, rd_line);
    read_i = 1'b0;
    tick();
    chk_b("rd_resp_pulse", resp_o, 1'b0);
    chk("rd_line_hold", line_o, rd_line);

    // Write; line_i changes after accept but the latched words go out in order
    write_i = 1'b1; line_i = wr_line; address_i = 32'h8000_00FF;
    tick();
    line_i = '1; write_i = 1'b0;
    chk_a("wr_addr", address_o, 32'h8000_00E0);
    for (int i = 0; i < 4; i++) begin
      chk_b("wr_write_o", write_o, 1'b1);
      chk_w("wr_burst_o", burst_o, wr_words[i]);
      chk_b("wr_resp", resp_o, 1'(Posted && (i == 0)));
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    chk_b("wr_write_o_low", write_o, 1'b0);
    chk_w("wr_burst_idle", burst_o, 64'h0);
    chk_b("wr_done_resp", resp_o, !Posted);
    chk("wr_line_o_kept", line_o, rd_line);
    tick();
    chk_b("wr_resp_pulse", resp_o, 1'b0);

    // Stalled read; address_i changes mid-burst
    read_i = 1'b1; address_i = 32'hABCD_EF3F;
    tick();
    address_i = 32'hFFFF_FFFF;
    for (int j = 0; j < 7; j++) begin
      chk_a("st_addr", address_o, 32'hABCD_EF20);
      chk_b("st_read_o", read_o, 1'b1);
      chk_b("st_no_resp", resp_o, 1'b0);
      resp_i = stall_pat[j]; burst_i = 64'hC0DE_0000_0000_0000 | 64'(j);
      tick();
    end
    resp_i = 1'b0; read_i = 1'b0;
    chk_b("st_resp", resp_o, 1'b1);
    chk("st_line", line_o, stall_line);
    chk_a("st_addr_done", address_o, 32'hABCD_EF20);
    tick();

    // Read and write together: read first, write accepted after the read's DONE
    read_i = 1'b1; write_i = 1'b1; line_i = both_line; address_i = 32'h0000_1040;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_b("both_read_o", read_o, 1'b1);
      chk_b("both_no_write", write_o, 1'b0);
      resp_i = 1'b1; burst_i = rd_words[3 - i];
      tick();
    end
    resp_i = 1'b0;
    chk_b("both_rd_resp", resp_o, 1'b1);
    chk_b("both_done_write_o", write_o, 1'b0);
    chk("both_rd_line", line_o, rev_line);
    read_i = 1'b0;
    tick();
    chk_b("both_idle_write_o", write_o, 1'b0);
    tick();
    write_i = 1'b0;
    chk_b("both_write_o", write_o, 1'b1);
    chk_b("both_read_o_low", read_o, 1'b0);
    chk_b("both_wr_resp", resp_o, Posted);
    for (int i = 0; i < 4; i++) begin
      chk_w("both_burst_o", burst_o, wr_words[3 - i]);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    chk_b("both_write_o_low", write_o, 1'b0);
    chk_b("both_wr_done", resp_o, !Posted);
    tick();

`ifdef BURST_LINE_ADAPTOR_POSTED_WRITE_EN
    // Posted write immediately followed by a read
    write_i = 1'b1; line_i = wr_line; address_i = 32'h0000_4000;
    tick();
    write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_5000;
    chk_b("pw_resp_c1", resp_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_b("pw_write_o", write_o, 1'b1);
      chk_b("pw_read_wait", read_o, 1'b0);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    chk_b("pw_write_o_low", write_o, 1'b0);
    chk_b("pw_no_done", resp_o, 1'b0);
    chk_b("pw_read_o_c5", read_o, 1'b0);
    tick();
    read_i = 1'b0;
    chk_b("pw_read_o", read_o, 1'b1);
    chk_a("pw_rd_addr", address_o, 32'h0000_5000);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = rd_words[i];
      tick();
    end
    resp_i = 1'b0;
    chk_b("pw_rd_resp", resp_o, 1'b1);
    chk("pw_rd_line", line_o, rd_line);
    tick();
`endif

    // Asynchronous reset after two beats of a read, then a clean read
    read_i = 1'b1; address_i = 32'h0000_2000;
    tick();
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      tick();
    end
    resp_i = 1'b0;
    chk_b("ar_read_o_pre", read_o, 1'b1);
    chk("ar_line_partial", 256'(line_o[127:0]),
        256'({64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000}));
    #2 reset = 1'b1;
    #1;
    chk_b("ar_read_o", read_o, 1'b0);
    chk("ar_line_o", line_o, 256'h0);
    chk_b("ar_resp_o", resp_o, 1'b0);
    chk_a("ar_address_o", address_o, 32'h0);
    tick();
    reset = 1'b0;
    read_i = 1'b1; address_i = 32'h0000_3010;
    tick();
    read_i = 1'b0;
    chk_b("ar2_read_o", read_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_b("ar2_no_resp", resp_o, 1'b0);
      resp_i = 1'b1; burst_i = rd_words[i];
      tick();
    end
    resp_i = 1'b0;
    chk_b("ar2_resp", resp_o, 1'b1);
    chk("ar2_line", line_o, rd_line);
    chk_a("ar2_addr", address_o, 32'h0000_3000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/burst_line_adaptor.md
# burst_line_adaptor

Parametrised adaptor between the last-level cache and the burst memory port. It converts one LINE_WIDTH-bit cache-line read or write into LINE_WIDTH/BURST_WIDTH memory beats and tolerates stalls between beats. It latches the request address and write data at accept, so the LLC may change `line_i` mid-burst. Optionally it posts writes so the LLC is released before the burst finishes.

## Interface
- LINE_WIDTH, 256, cache-line width in bits
- BURST_WIDTH, 64, memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH must be a power of two, at least 2
- ADDR_WIDTH, 32, address width
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- line_i  in  LINE_WIDTH  write line from LLC
- line_o  out  LINE_WIDTH  read line to LLC; registered
- address_i  in  ADDR_WIDTH  LLC request address
- read_i / write_i  in  1 each  LLC request strobes, held until resp_o
- resp_o  out  1  single-cycle completion pulse to LLC
- burst_i  in  BURST_WIDTH  read beat from memory
- burst_o  out  BURST_WIDTH  write beat to memory
- address_o  out  ADDR_WIDTH  line-aligned latched address
- read_o / write_o  out  1 each  memory request, held for the whole burst
- resp_i  in  1  memory beat-valid; one beat transfers per cycle it is high

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i has priority over write_i when both are high.
  - On accept: latch address_i with low log2(LINE_WIDTH/8) bits zeroed, and clear the beat counter.
  - On a write accept, additionally latch line_i into the write buffer.
  - Next state is READ or WRITE.
- READ:
  - read_o=1.
  - On each resp_i=1: store burst_i into line_o[beat*BURST_WIDTH +: BURST_WIDTH] and increment beat.
  - On resp_i with beat==BEATS-1, go to DONE.
  - resp_i=0 stalls; state and beat hold.
- WRITE:
  - write_o=1.
  - burst_o = wbuf[beat*BURST_WIDTH +: BURST_WIDTH], combinational from the counter.
  - Advances exactly like READ.
- DONE: resp_o=1 for one cycle, then IDLE. read_i/write_i are ignored in DONE.
- Outside READ/WRITE: read_o=write_o=0, burst_o=0, address_o holds its last latched value.
- line_o holds the last read line until the next read overwrites it beat by beat. It is never modified by writes.
- Reset (async, any state, including mid-burst): state=IDLE; beat=0; line_o, wbuf and address latch cleared; all outputs 0. A partial burst is abandoned, and memory must tolerate request withdrawal.

## Timing
- Request visible in cycle 0 → read_o/write_o high from cycle 1.
- With resp_i high every cycle, the last beat lands in cycle BEATS and resp_o pulses in cycle BEATS+1. That is 5 cycles for the defaults.
- Each stall cycle adds one cycle.
- line_o is complete and stable in the resp_o cycle and stays stable afterward.
- Back-to-back requests: the earliest next accept is the IDLE cycle after DONE. Minimum per-line occupancy is BEATS+2 cycles.
- address_o is stable for the whole burst, independent of address_i changes.

## Configuration
- `BURST_LINE_ADAPTOR_POSTED_WRITE_EN` defined:
  - A write pulses resp_o in the first WRITE cycle.
  - After the final beat the FSM returns directly to IDLE, skipping DONE.
  - Requests arriving during the posted write wait: read_i/write_i stay pending and are accepted in the following IDLE cycle.
  - Reads are unchanged.
- Undefined: writes complete through DONE exactly like reads. No early resp_o.

## Structure
- Package `burst_adaptor_pkg`: state enum typedef, and a localparam function computing BEATS and the offset-bit count from the parameters.
- One sub-module, `burst_beat_counter`: log2(BEATS)-bit counter with clear, enable on resp_i, and a last-beat flag. Same async active-high reset.

## Test plan
- Read, defaults, resp_i high 4 cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; resp_o exactly in cycle 5; read_o high cycles 1–4.
- Write with line_i changed to all-ones after accept → burst_o carries the originally latched four words in order; write_o high until the 4th resp_i.
- resp_i toggling 1,0,0,1,1,0,1 → exactly 4 beats captured, no duplication or skip; address_o = address_i & ~0x1F throughout.
- read_i and write_i both high in IDLE → read performed, write_o never asserted; write accepted after the read's DONE.
- reset asserted after beat 2 of a read → read_o, line_o and resp_o go 0 asynchronously; the next read completes normally from beat 0.
- POSTED_WRITE_EN defined, write then immediate read → resp_o in cycle 1; read_o rises only after write_o falls; no DONE cycle after the write.
